apu_frame_sequencer: RTL and testbench
======================================

# apu_frame_sequencer

Consumes the timer's `apu_framecount_en` pulse (DIV bit 4/5 falling edge) and runs the APU's 8-step frame sequencer. Emits the 256 Hz length, 128 Hz sweep and 64 Hz envelope clock pulses, and owns the four channel length counters, including the DMG/CGB length quirks. Sits between the timer and the APU channel blocks, which consume its clock pulses and channel-disable pulses.

## Interface
Parameters:
- `SQ_LEN_BITS`, default 6: length counter width for ch1, ch2 and ch4.
- `WAVE_LEN_BITS`, default 8: length counter width for ch3.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `ce` in 1: CPU clock enable; all state advances only when `ce`=1.
- `apu_framecount_en` in 1: frame sequencer tick from the timer; valid only when `ce`=1.
- `apu_on` in 1: NR52 bit 7.
- `is_gbc` in 1: CGB mode.
- `len_wr` in 4: NRx1 write strobe, one bit per channel.
- `nrx4_wr` in 4: NRx4 write strobe, one bit per channel.
- `cpu_di` in 8: write data.
- `len_en` out 4: current NRx4 bit 6 per channel.
- `sweep_clk` out 1: one-cycle pulse.
- `env_clk` out 1: one-cycle pulse.
- `len_expired` out 4: one-cycle disable pulse per channel.
- `step` out 3: current step index.

## Operation
- Step schedule:
  - Length clock on steps 0, 2, 4, 6.
  - Sweep clock on steps 2, 6.
  - Envelope clock on step 7.
  - Steps 1, 3, 5 do nothing.
- On `ce && apu_framecount_en && apu_on`: execute the current step, then `step` <= `step`+1 (mod 8, 7 wraps to 0).
- `apu_on`=0: `step` held at 0 and no pulses are emitted.
  - CGB: length counters and `len_en` are cleared.
  - DMG: length counters are retained.
- NRx1 write: counter <= MAX − `cpu_di[BITS-1:0]`. MAX is 64 for ch1/ch2/ch4 and 256 for ch3. The loaded value is never 0.
- NRx4 write: `len_en` <= `cpu_di[6]`. `cpu_di[7]` is the trigger.
  - Trigger with counter 0 reloads MAX.
- Length clock with `len_en`=1 and counter ≠ 0: decrement. Reaching 0 pulses `len_expired`.
- Counter 0 stays 0; no repeated expiry pulse.
- Counter width arithmetic is unsigned and never wraps below 0.

## Timing
- Reset values: `step`=0, all counters 0, `len_en`=0, and all pulse outputs 0.
- Pulse outputs are registered. They assert the `clk_sys` cycle after the qualifying `ce` tick and last exactly one `clk_sys` cycle.
- Write strobes are sampled on `ce`. Their effect is visible on the next `ce`-qualified length clock.
- Same-`ce` ordering: frame step first, then NRx1 write, then NRx4 enable/trigger.
  - An NRx1 write coincident with a length clock wins: the loaded value is not decremented.
  - A trigger coincident with expiry suppresses the `len_expired` pulse.
- When `reset_n`=0 mid-sequence, everything returns to reset values on the next `clk_sys` edge. Any in-flight pulse is dropped.

## Configuration
- `APU_LENGTH_QUIRKS_EN` defined enables two quirks. Both apply only when the next step is not a length step, i.e. the current `step` is odd.
  - Extra clock: an NRx4 write changing `len_en` 0→1 with counter ≠ 0 decrements immediately. Reaching 0 without a trigger pulses `len_expired`.
  - Short reload: a trigger reloading from 0 with `len_en`=1 loads MAX−1.
- Undefined: enable and trigger follow the plain rules above and no extra clocking occurs.

## Structure
- Shared package `apu_pkg`: step constants (`STEP_LEN_MASK`=8'b0101_0101, `STEP_SWEEP_MASK`=8'b0100_0100, `STEP_ENV_MASK`=8'b1000_0000), `LEN_MAX_SQ`=64 and `LEN_MAX_WAVE`=256.
- Sub-module `apu_length_counter`, parameterised by `WIDTH`, instantiated 4×. It holds the counter, `len_en`, the quirk logic and the expiry pulse.
- The top level holds the step counter and the pulse registers.

## Test plan
- Apply 8 `apu_framecount_en` ticks with `apu_on`=1: expect length pulses internally at steps 0, 2, 4, 6, `sweep_clk` at steps 2 and 6, `env_clk` once at step 7, and `step` back at 0.
- ch1 NRx1=0x3E, NRx4=0x40, then 2 length clocks: expect a `len_expired[0]` pulse after the 2nd clock, and counter 0 after further clocks with no further pulse.
- ch3 NRx1=0x00 (counter 256), enabled: expect expiry after exactly 256 length clocks.
- With the macro defined: at `step`=1 and counter=1, write NRx4=0x40 → `len_expired` pulses immediately. At `step`=1, trigger with NRx4=0xC0 and counter 0 → counter=63.
- Drop `apu_on` at `step`=5: expect `step`=0 and no pulses. On `is_gbc`=1 counters read 0; on `is_gbc`=0 the counter value is retained.
- NRx1 write coincident with a length-clock `ce`: the loaded value is not decremented on that tick.

Source files
------------

// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared frame sequencer constants for the APU
//
// Purpose: step schedule masks (bit N set = action on step N) and the
// length counter reload maxima used by the frame sequencer and its users.
// Ports: none (package).
package apu_pkg;

  localparam logic [7:0] STEP_LEN_MASK   = 8'b0101_0101;
  localparam logic [7:0] STEP_SWEEP_MASK = 8'b0100_0100;
  localparam logic [7:0] STEP_ENV_MASK   = 8'b1000_0000;

  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  // True when the given step index is scheduled in the mask.
  function automatic logic step_hits(input logic [7:0] mask, input logic [2:0] s);
    return mask[s];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// rtl/apu_length_counter.sv - one APU channel length counter with enable and expiry pulse
//
// Purpose: holds a channel's length counter and NRx4 length-enable bit,
// decrements on frame length clocks, and emits a one-cycle expiry pulse.
// Optional macro APU_LENGTH_QUIRKS_EN adds the extra-clock and short-reload
// behaviour that applies while the current frame step is odd.
// Ports:
//   clk_sys, reset_n  - clock, synchronous active-low reset
//   ce                - clock enable; state only advances when high
//   len_clk           - length clock for this ce (already ce-qualified by top)
//   off_clear         - APU off in CGB mode: clear counter and enable
//   step_odd          - current frame step is odd (quirk window)
//   len_wr, nrx4_wr   - NRx1 / NRx4 write strobes for this channel
//   cpu_di            - write data
//   len_en            - NRx4 bit 6
//   len_expired       - one-cycle pulse when the counter runs out
module apu_length_counter
  import apu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       len_clk,
  input  logic       off_clear,
  input  logic       step_odd,
  input  logic       len_wr,
  input  logic       nrx4_wr,
  input  logic [7:0] cpu_di,
  output logic       len_en,
  output logic       len_expired
);

  // One extra bit so the counter can hold MAX itself.
  localparam logic [WIDTH:0] MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] count;
  logic [WIDTH:0] cnt_nxt;
  logic [WIDTH:0] load_val;
  logic           en_nxt;
  logic           exp_nxt;
  logic           short_reload;

  // NRx1 load: MAX - data, so a zero write loads the full MAX (never 0).
  assign load_val = MAX - {1'b0, cpu_di[WIDTH-1:0]};

`ifdef APU_LENGTH_QUIRKS_EN
  assign short_reload = step_odd & cpu_di[6];
`else
  logic unused_step_odd;
  assign unused_step_odd = step_odd;
  assign short_reload    = 1'b0;
`endif

  // Ordering within one ce: frame length clock, then NRx1 load, then NRx4.
  always_comb begin
    cnt_nxt = count;
    en_nxt  = len_en;
    exp_nxt = 1'b0;

    if (len_clk && len_en && (count != '0)) begin
      cnt_nxt = count - ONE;
      exp_nxt = (count == ONE);
    end

    // A load on the same tick replaces the decremented value outright.
    if (len_wr) begin
      cnt_nxt = load_val;
      exp_nxt = 1'b0;
    end

    if (nrx4_wr) begin
      en_nxt = cpu_di[6];
`ifdef APU_LENGTH_QUIRKS_EN
      // Enabling length mid-period clocks the counter once immediately.
      if (step_odd && !len_en && cpu_di[6] && (cnt_nxt != '0)) begin
        cnt_nxt = cnt_nxt - ONE;
        if ((cnt_nxt == '0) && !cpu_di[7]) exp_nxt = 1'b1;
      end
`endif
      // Trigger cancels any expiry on this tick and refills an empty counter.
      if (cpu_di[7]) begin
        exp_nxt = 1'b0;
        if (cnt_nxt == '0) cnt_nxt = short_reload ? (MAX - ONE) : MAX;
      end
    end

    if (off_clear) begin
      cnt_nxt = '0;
      en_nxt  = 1'b0;
      exp_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      count       <= '0;
      len_en      <= 1'b0;
      len_expired <= 1'b0;
    end else begin
      len_expired <= 1'b0;
      if (ce) begin
        count       <= cnt_nxt;
        len_en      <= en_nxt;
        len_expired <= exp_nxt;
      end
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// rtl/apu_frame_sequencer.sv - APU 8-step frame sequencer with channel length counters
//
// Purpose: counts timer frame ticks through the 8-step schedule, emits
// registered sweep/envelope pulses, and drives four length counters
// (ch1, ch2, ch4 of SQ_LEN_BITS; ch3 of WAVE_LEN_BITS).
// Optional macro APU_LENGTH_QUIRKS_EN enables the length quirks in the
// length counters.
// Ports:
//   clk_sys, reset_n     - clock, synchronous active-low reset
//   ce                   - CPU clock enable
//   apu_framecount_en    - frame tick from the timer (valid with ce)
//   apu_on, is_gbc       - NR52 power bit, CGB mode
//   len_wr, nrx4_wr      - NRx1 / NRx4 write strobes, bit N = channel N+1
//   cpu_di               - write data
//   len_en               - per-channel NRx4 bit 6
//   sweep_clk, env_clk   - one-cycle 128 Hz / 64 Hz pulses
//   len_expired          - per-channel one-cycle disable pulse
//   step                 - current step index
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int SQ_LEN_BITS   = 6,
  parameter int WAVE_LEN_BITS = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       apu_framecount_en,
  input  logic       apu_on,
  input  logic       is_gbc,
  input  logic [3:0] len_wr,
  input  logic [3:0] nrx4_wr,
  input  logic [7:0] cpu_di,
  output logic [3:0] len_en,
  output logic       sweep_clk,
  output logic       env_clk,
  output logic [3:0] len_expired,
  output logic [2:0] step
);

  logic frame_tick;
  logic len_clk;
  logic off_clear;

  assign frame_tick = ce & apu_framecount_en & apu_on;
  // Length clock goes straight to the counters; their expiry is registered there.
  assign len_clk    = frame_tick & step_hits(STEP_LEN_MASK, step);
  assign off_clear  = ~apu_on & is_gbc;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      step      <= 3'd0;
      sweep_clk <= 1'b0;
      env_clk   <= 1'b0;
    end else begin
      sweep_clk <= 1'b0;
      env_clk   <= 1'b0;
      if (ce) begin
        if (!apu_on) begin
          step <= 3'd0;
        end else if (apu_framecount_en) begin
          sweep_clk <= step_hits(STEP_SWEEP_MASK, step);
          env_clk   <= step_hits(STEP_ENV_MASK, step);
          step      <= step + 3'd1;
        end
      end
    end
  end

  apu_length_counter #(.WIDTH(SQ_LEN_BITS)) u_len_ch1 (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce          (ce),
    .len_clk     (len_clk),
    .off_clear   (off_clear),
    .step_odd    (step[0]),
    .len_wr      (len_wr[0]),
    .nrx4_wr     (nrx4_wr[0]),
    .cpu_di      (cpu_di),
    .len_en      (len_en[0]),
    .len_expired (len_expired[0])
  );

  apu_length_counter #(.WIDTH(SQ_LEN_BITS)) u_len_ch2 (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce          (ce),
    .len_clk     (len_clk),
    .off_clear   (off_clear),
    .step_odd    (step[0]),
    .len_wr      (len_wr[1]),
    .nrx4_wr     (nrx4_wr[1]),
    .cpu_di      (cpu_di),
    .len_en      (len_en[1]),
    .len_expired (len_expired[1])
  );

  apu_length_counter #(.WIDTH(WAVE_LEN_BITS)) u_len_ch3 (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce          (ce),
    .len_clk     (len_clk),
    .off_clear   (off_clear),
    .step_odd    (step[0]),
    .len_wr      (len_wr[2]),
    .nrx4_wr     (nrx4_wr[2]),
    .cpu_di      (cpu_di),
    .len_en      (len_en[2]),
    .len_expired (len_expired[2])
  );

  apu_length_counter #(.WIDTH(SQ_LEN_BITS)) u_len_ch4 (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce          (ce),
    .len_clk     (len_clk),
    .off_clear   (off_clear),
    .step_odd    (step[0]),
    .len_wr      (len_wr[3]),
    .nrx4_wr     (nrx4_wr[3]),
    .cpu_di      (cpu_di),
    .len_en      (len_en[3]),
    .len_expired (len_expired[3])
  );

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb/tb_apu_frame_sequencer.sv - self-checking bench for apu_frame_sequencer
module tb_apu_frame_sequencer;
  import apu_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n, ce, apu_framecount_en, apu_on, is_gbc;
  logic [3:0] len_wr, nrx4_wr;
  logic [7:0] cpu_di;
  logic [3:0] len_en, len_expired;
  logic       sweep_clk, env_clk;
  logic [2:0] step;

  always #5 clk_sys = ~clk_sys;

  apu_frame_sequencer dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .ce                (ce),
    .apu_framecount_en (apu_framecount_en),
    .apu_on            (apu_on),
    .is_gbc            (is_gbc),
    .len_wr            (len_wr),
    .nrx4_wr           (nrx4_wr),
    .cpu_di            (cpu_di),
    .len_en            (len_en),
    .sweep_clk         (sweep_clk),
    .env_clk           (env_clk),
    .len_expired       (len_expired),
    .step              (step)
  );

  typedef struct packed {
    logic       sweep;
    logic       env;
    logic [3:0] lexp;
    logic [2:0] stp;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, e;
  logic got_len_clk;
  int   m_step;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic obs_t frame_exp(input int s, input logic fc, input logic [3:0] le);
    obs_t r;
    r.sweep = fc && (s == 2 || s == 6);
    r.env   = fc && (s == 7);
    r.lexp  = le;
    r.stp   = fc ? 3'((s + 1) % 8) : 3'(s);
    return r;
  endfunction

  // Drive one clk_sys cycle, capture outputs #1 after the edge, update step model.
  task automatic cyc(input logic c, input logic fc, input logic [3:0] lw,
                     input logic [3:0] nw, input logic [7:0] d);
    ce = c; apu_framecount_en = fc; len_wr = lw; nrx4_wr = nw; cpu_di = d;
    #1 got_len_clk = dut.len_clk;
    @(posedge clk_sys);
    #1;
    got = '{sweep_clk, env_clk, len_expired, step};
    ce = 1'b0; apu_framecount_en = 1'b0; len_wr = 4'h0; nrx4_wr = 4'h0; cpu_di = 8'h00;
    if (!reset_n) m_step = 0;
    else if (c) m_step = apu_on ? (fc ? (m_step + 1) % 8 : m_step) : 0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; apu_on = 1'b1; is_gbc = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'hF, 4'hF, 8'hC0);
    exp_q.push_back(obs_t'(0));
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", got, e); end
    n_vec++;
    if (len_en !== 4'h0) begin n_bad++; $display("FAIL reset_len_en: got %b want 0000", len_en); end
    reset_n = 1'b1;
  endtask

  task automatic test_sequence;
    int s;
    for (int i = 0; i < 8; i++) begin
      s = m_step;
      exp_q.push_back(frame_exp(s, 1'b1, 4'h0));
      cyc(1, 1, 4'h0, 4'h0, 8'h00);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL seq_tick%0d: got %h want %h", s, got, e); end
      n_vec++;
      if (got_len_clk !== (s % 2 == 0)) begin
        n_bad++; $display("FAIL seq_len_clk%0d: got %b want %b", s, got_len_clk, (s % 2 == 0));
      end
      // Pulses last one cycle; an idle cycle must show them low again.
      exp_q.push_back(frame_exp(m_step, 1'b0, 4'h0));
      cyc(0, 1, 4'h0, 4'h0, 8'h00);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL seq_idle%0d: got %h want %h", s, got, e); end
    end
    n_vec++;
    if (step !== 3'd0) begin n_bad++; $display("FAIL seq_wrap: got %0d want 0", step); end
  endtask

  task automatic test_ch1_expiry;
    int s, lc;
    cyc(1, 0, 4'b0001, 4'h0, 8'h3E);
    cyc(1, 0, 4'h0, 4'b0001, 8'h40);
    n_vec++;
    if (len_en !== 4'b0001) begin n_bad++; $display("FAIL ch1_len_en: got %b want 0001", len_en); end
    lc = 0;
    for (int i = 0; i < 12; i++) begin
      s = m_step;
      if (s % 2 == 0) lc++;
      exp_q.push_back(frame_exp(s, 1'b1, (s % 2 == 0 && lc == 2) ? 4'b0001 : 4'h0));
      cyc(1, 1, 4'h0, 4'h0, 8'h00);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL ch1_tick%0d: got %h want %h", i, got, e); end
    end
    n_vec++;
    if (dut.u_len_ch1.count !== 7'd0) begin
      n_bad++; $display("FAIL ch1_count_zero: got %0d want 0", dut.u_len_ch1.count);
    end
  endtask

  task automatic test_wave_256;
    int s, lc, npulse, at;
    cyc(1, 0, 4'b0100, 4'h0, 8'h00);
    cyc(1, 0, 4'h0, 4'b0100, 8'h40);
    lc = 0; npulse = 0; at = -1;
    for (int i = 0; i < 520; i++) begin
      s = m_step;
      if (s % 2 == 0) lc++;
      exp_q.push_back(frame_exp(s, 1'b1, (s % 2 == 0 && lc == 256) ? 4'b0100 : 4'h0));
      cyc(1, 1, 4'h0, 4'h0, 8'h00);
      if (got.lexp[2]) begin npulse++; at = lc; end
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL wave_tick%0d: got %h want %h", i, got, e); end
    end
    n_vec++;
    if (npulse != 1 || at != 256) begin
      n_bad++; $display("FAIL wave_expiry: got %0d pulses at clock %0d want 1 at 256", npulse, at);
    end
  endtask

  task automatic test_quirks;
    logic [3:0] want_pulse;
    logic [6:0] want_after_en, want_after_trig;
`ifdef APU_LENGTH_QUIRKS_EN
    want_pulse = 4'b0010; want_after_en = 7'd0; want_after_trig = 7'd63;
`else
    want_pulse = 4'b0000; want_after_en = 7'd1; want_after_trig = 7'd1;
`endif
    for (int i = 0; i < 8 && m_step != 1; i++) cyc(1, 1, 4'h0, 4'h0, 8'h00);
    n_vec++;
    if (step !== 3'd1) begin n_bad++; $display("FAIL quirk_step: got %0d want 1", step); end
    cyc(1, 0, 4'b0010, 4'h0, 8'h3F);
    exp_q.push_back(frame_exp(1, 1'b0, want_pulse));
    cyc(1, 0, 4'h0, 4'b0010, 8'h40);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL quirk_extra_clock: got %h want %h", got, e); end
    n_vec++;
    if (dut.u_len_ch2.count !== want_after_en) begin
      n_bad++; $display("FAIL quirk_count_en: got %0d want %0d", dut.u_len_ch2.count, want_after_en);
    end
    exp_q.push_back(frame_exp(1, 1'b0, 4'h0));
    cyc(1, 0, 4'h0, 4'b0010, 8'hC0);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL quirk_trig_pulse: got %h want %h", got, e); end
    n_vec++;
    if (dut.u_len_ch2.count !== want_after_trig) begin
      n_bad++; $display("FAIL quirk_short_reload: got %0d want %0d", dut.u_len_ch2.count, want_after_trig);
    end
    cyc(1, 0, 4'h0, 4'b0010, 8'h00);
  endtask

  task automatic test_apu_off;
    for (int i = 0; i < 8 && m_step != 4; i++) cyc(1, 1, 4'h0, 4'h0, 8'h00);
    cyc(1, 0, 4'b1000, 4'h0, 8'h30);
    cyc(1, 0, 4'h0, 4'b1000, 8'h40);
    cyc(1, 1, 4'h0, 4'h0, 8'h00);
    n_vec++;
    if (step !== 3'd5) begin n_bad++; $display("FAIL off_pre_step: got %0d want 5", step); end
    apu_on = 1'b0; is_gbc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(obs_t'(0));
      cyc(1, 1, 4'h0, 4'h0, 8'h00);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL off_dmg%0d: got %h want %h", i, got, e); end
    end
    n_vec++;
    if (dut.u_len_ch4.count !== 7'd15) begin
      n_bad++; $display("FAIL off_dmg_retain: got %0d want 15", dut.u_len_ch4.count);
    end
    n_vec++;
    if (len_en !== 4'b1101) begin n_bad++; $display("FAIL off_dmg_len_en: got %b want 1101", len_en); end
    is_gbc = 1'b1;
    cyc(1, 1, 4'h0, 4'h0, 8'h00);
    n_vec++;
    if (dut.u_len_ch4.count !== 7'd0 || len_en !== 4'h0) begin
      n_bad++; $display("FAIL off_cgb_clear: got count %0d len_en %b want 0 0000", dut.u_len_ch4.count, len_en);
    end
    apu_on = 1'b1; is_gbc = 1'b0;
  endtask

  task automatic test_write_coincident;
    cyc(1, 0, 4'h0, 4'b0001, 8'h40);
    exp_q.push_back(frame_exp(0, 1'b1, 4'h0));
    cyc(1, 1, 4'b0001, 4'h0, 8'h3C);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL coinc_tick: got %h want %h", got, e); end
    n_vec++;
    if (dut.u_len_ch1.count !== 7'd4) begin
      n_bad++; $display("FAIL coinc_no_decrement: got %0d want 4", dut.u_len_ch1.count);
    end
    cyc(1, 1, 4'h0, 4'h0, 8'h00);
    cyc(1, 1, 4'h0, 4'h0, 8'h00);
    n_vec++;
    if (dut.u_len_ch1.count !== 7'd3) begin
      n_bad++; $display("FAIL coinc_next_clock: got %0d want 3", dut.u_len_ch1.count);
    end
  endtask

  task automatic test_ce_gate;
    int s;
    s = m_step;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(frame_exp(s, 1'b0, 4'h0));
      cyc(0, 1, 4'h0, 4'h0, 8'h00);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL ce_gate%0d: got %h want %h", i, got, e); end
    end
  endtask

  task automatic test_reset_midseq;
    for (int i = 0; i < 8 && m_step != 6; i++) cyc(1, 1, 4'h0, 4'h0, 8'h00);
    reset_n = 1'b0;
    exp_q.push_back(obs_t'(0));
    cyc(1, 1, 4'h0, 4'h0, 8'h00);
    reset_n = 1'b1;
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL reset_mid_drop: got %h want %h", got, e); end
    n_vec++;
    if (len_en !== 4'h0 || dut.u_len_ch1.count !== 7'd0) begin
      n_bad++; $display("FAIL reset_mid_state: got len_en %b count %0d want 0000 0", len_en, dut.u_len_ch1.count);
    end
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; apu_framecount_en = 1'b0; apu_on = 1'b0; is_gbc = 1'b0;
    len_wr = 4'h0; nrx4_wr = 4'h0; cpu_di = 8'h00; m_step = 0;
    test_reset;
    test_sequence;
    test_ch1_expiry;
    test_wave_256;
    test_quirks;
    test_apu_off;
    test_write_coincident;
    test_ce_gate;
    test_reset_midseq;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
